// File: rtl/kbd_text_pkg.sv
// Shared types and constants for the keyboard text controller.
// Optional feature macro: KBD_SCROLL_EN (see kbd_text_ctrl).
package kbd_text_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR_ALL = 3'd0,
        ST_IDLE      = 3'd1,
        ST_LOOKUP    = 3'd2,
        ST_ACT       = 3'd3,
        ST_WRITE     = 3'd4,
        ST_CLEAR_ROW = 3'd5
    } state_e;

    localparam logic [7:0] SC_BREAK     = 8'hF0;
    localparam logic [7:0] SC_EXT       = 8'hE0;
    localparam logic [7:0] ASC_CR       = 8'h0D;
    localparam logic [7:0] ASC_BS       = 8'h08;
    localparam logic [7:0] ASC_PRINT_LO = 8'h20;
    localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

    // VRAM rows are on a 128-byte stride: row in the upper bits, column below.
    function automatic logic [11:0] vram_addr_pack(input logic [4:0] row, input logic [6:0] col);
        return {row, col};
    endfunction

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASC_PRINT_LO) && (c <= ASC_PRINT_HI);
    endfunction

endpackage

// File: rtl/kbd_text_ctrl_row_clear.sv
// Column sweep counter shared by the full-screen clear and the single-row clear.
// Wraps to 0 by itself after the last column so the next sweep starts clean.
module kbd_row_clear
    import kbd_text_pkg::*;
#(
    parameter int COLS = 70
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       step,
    output logic [6:0] col,
    output logic       last
);

    logic [6:0] col_q, col_d;

    // Next column: restart to 0, or advance and wrap after the last column.
    always_comb begin
        col_d = col_q;
        if (restart) begin
            col_d = '0;
        end else if (step) begin
            col_d = last ? 7'd0 : col_q + 7'd1;
        end
    end

    // Column register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q <= '0;
        end else begin
            col_q <= col_d;
        end
    end

    assign col  = col_q;
    assign last = (col_q == 7'(COLS - 1));

endmodule

// File: rtl/kbd_text_ctrl.sv
// Keyboard-to-screen text sequencer: scancode handshake, ROM lookup, cursor,
// line wrap, newline/backspace and row clearing on a single VRAM write port.
// Optional feature macro: KBD_SCROLL_EN keeps the cursor row at the bottom of
// the display once the screen has filled; otherwise disp_top stays 0.
module kbd_text_ctrl
    import kbd_text_pkg::*;
#(
    parameter int         COLS  = 70,
    parameter int         ROWS  = 30,
    parameter logic [7:0] BLANK = 8'h20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        kb_valid,
    input  logic [7:0]  kb_code,
    output logic        kb_ready,
    output logic [7:0]  rom_addr,
    input  logic [7:0]  rom_data,
    output logic        vram_we,
    output logic [11:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic [6:0]  cur_col,
    output logic [4:0]  cur_row,
    output logic [4:0]  disp_top,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [4:0]  clr_row_q, clr_row_d;
    logic        filled_q, filled_d;
    logic        brk_q, brk_d;
    logic        ext_q, ext_d;
    logic        kb_ready_q, kb_ready_d;
    logic        busy_q, busy_d;
    logic        vram_we_q, vram_we_d;
    logic [4:0]  disp_top_q, disp_top_d;
    logic [7:0]  rom_addr_q, rom_addr_d;
    logic [11:0] vram_addr_q, vram_addr_d;
    logic [7:0]  vram_wdata_q, vram_wdata_d;

    logic        clr_restart, clr_step, clr_last, newline;
    logic [6:0]  clr_col;

    kbd_row_clear #(.COLS(COLS)) u_row_clear (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (clr_restart),
        .step    (clr_step),
        .col     (clr_col),
        .last    (clr_last)
    );

    // Next-state, cursor and VRAM write decisions for every FSM state.
    always_comb begin
        state_d      = state_q;
        col_d        = col_q;
        row_d        = row_q;
        clr_row_d    = clr_row_q;
        filled_d     = filled_q;
        brk_d        = brk_q;
        ext_d        = ext_q;
        rom_addr_d   = rom_addr_q;
        vram_we_d    = 1'b0;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        clr_restart  = 1'b0;
        clr_step     = 1'b0;
        newline      = 1'b0;

        case (state_q)
            ST_CLEAR_ALL: begin
                vram_we_d    = 1'b1;
                vram_addr_d  = vram_addr_pack(clr_row_q, clr_col);
                vram_wdata_d = BLANK;
                clr_step     = 1'b1;
                if (clr_last) begin
                    if (clr_row_q == 5'(ROWS - 1)) begin
                        clr_row_d = '0;
                        state_d   = ST_IDLE;
                    end else begin
                        clr_row_d = clr_row_q + 5'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (kb_valid && kb_ready_q) begin
                    if (kb_code == SC_BREAK) begin
                        brk_d = 1'b1;
                    end else if (kb_code == SC_EXT) begin
                        ext_d = 1'b1;
                    end else if (brk_q) begin
                        // Release of a key: swallow the code that follows the break prefix.
                        brk_d = 1'b0;
                        ext_d = 1'b0;
                    end else begin
                        rom_addr_d = kb_code;
                        state_d    = ST_LOOKUP;
                    end
                end
            end
            ST_LOOKUP: begin
                state_d = ST_ACT;
            end
            ST_ACT: begin
                ext_d = 1'b0;
                if (is_printable(rom_data)) begin
                    vram_we_d    = 1'b1;
                    vram_addr_d  = vram_addr_pack(row_q, col_q);
                    vram_wdata_d = rom_data;
                    state_d      = ST_WRITE;
                end else if (rom_data == ASC_CR) begin
                    newline = 1'b1;
                end else if ((rom_data == ASC_BS) && (col_q != 7'd0)) begin
                    col_d        = col_q - 7'd1;
                    vram_we_d    = 1'b1;
                    vram_addr_d  = vram_addr_pack(row_q, col_q - 7'd1);
                    vram_wdata_d = BLANK;
                    state_d      = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                // The character strobe is on the port now; advance the cursor or wrap.
                if (col_q == 7'(COLS - 1)) begin
                    newline = 1'b1;
                end else begin
                    col_d   = col_q + 7'd1;
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR_ROW: begin
                vram_we_d    = 1'b1;
                vram_addr_d  = vram_addr_pack(row_q, clr_col);
                vram_wdata_d = BLANK;
                clr_step     = 1'b1;
                if (clr_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_CLEAR_ALL;
            end
        endcase

        if (newline) begin
            col_d       = '0;
            clr_restart = 1'b1;
            state_d     = ST_CLEAR_ROW;
            if (row_q == 5'(ROWS - 1)) begin
                row_d    = '0;
                filled_d = 1'b1;
            end else begin
                row_d = row_q + 5'd1;
            end
        end

        kb_ready_d = (state_d == ST_IDLE);
        busy_d     = (state_d != ST_IDLE);

`ifdef KBD_SCROLL_EN
        if (filled_d) begin
            disp_top_d = (row_d == 5'(ROWS - 1)) ? 5'd0 : row_d + 5'd1;
        end else begin
            disp_top_d = '0;
        end
`else
        disp_top_d = '0;
`endif
    end

    // Control state and cursor; reset aborts any clear or lookup in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR_ALL;
            col_q      <= '0;
            row_q      <= '0;
            clr_row_q  <= '0;
            filled_q   <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            kb_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            vram_we_q  <= 1'b0;
            disp_top_q <= '0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            clr_row_q  <= clr_row_d;
            filled_q   <= filled_d;
            brk_q      <= brk_d;
            ext_q      <= ext_d;
            kb_ready_q <= kb_ready_d;
            busy_q     <= busy_d;
            vram_we_q  <= vram_we_d;
            disp_top_q <= disp_top_d;
        end
    end

    // Address/data registers; only meaningful while their strobe is high.
    always_ff @(posedge clk) begin
        rom_addr_q   <= rom_addr_d;
        vram_addr_q  <= vram_addr_d;
        vram_wdata_q <= vram_wdata_d;
    end

    assign kb_ready   = kb_ready_q;
    assign busy       = busy_q;
    assign rom_addr   = rom_addr_q;
    assign vram_we    = vram_we_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;
    assign cur_col    = col_q;
    assign cur_row    = row_q;
    assign disp_top   = disp_top_q;

endmodule
